mem_port_arbiter: RTL and testbench

- Shares the single core memory port between the instruction-fetch requester (I) and the MEM-stage data requester (D), including locked read-modify-write sequences for the custom atomic opcode.
- Sits between the pipeline stages and the unified cache/memory interface (mem_addr/mem_wr/mem_wdata/mem_rdata/mem_ready).
- Issues one transaction at a time, returns read data and a done pulse to the owner, and bounds starvation and lock duration.

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between fetch (I) and data (D) requesters.
// Supports locked D read-modify-write sequences with starvation and lock bounds.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int D_STREAK_MAX = 4,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_done,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic                  d_lock,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  locked,
    output logic                  lock_err
);

    localparam int SW = $clog2(D_STREAK_MAX + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_I_ACC  = 3'd1;
    localparam logic [2:0] S_D_ACC  = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  i_done_q, i_done_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic                  d_done_q, d_done_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  locked_q, locked_d;
    logic                  lock_err_q, lock_err_d;
    logic                  lock_q, lock_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic grant_i;
    logic grant_d;

    // In LOCKED only D may win; in IDLE a saturated streak forces I.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (d_req && !(i_req && streak_q == STREAK_MAX)) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end else if (state_q == S_LOCKED) begin
            grant_d = d_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wr_d    = mem_wr_q;
        mem_wdata_d = mem_wdata_q;
        i_done_d    = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_done_d    = 1'b0;
        d_rdata_d   = d_rdata_q;
        locked_d    = locked_q;
        lock_err_d  = lock_err_q;
        lock_d      = lock_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;

        unique case (state_q)
            S_IDLE: ;
            S_LOCKED: begin
                if (!d_req) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d    = S_IDLE;
                        locked_d   = 1'b0;
                        lock_err_d = 1'b1;
                        tmo_d      = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            S_I_ACC: begin
                if (mem_ready) begin
                    i_rdata_d = mem_rdata;
                    i_done_d  = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_D_ACC: begin
                if (mem_ready) begin
                    d_rdata_d = mem_wr_q ? '0 : mem_rdata;
                    d_done_d  = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                state_d  = lock_q ? S_LOCKED : S_IDLE;
                locked_d = lock_q;
            end
            default: state_d = S_IDLE;
        endcase

        if (grant_d) begin
            state_d     = S_D_ACC;
            mem_req_d   = 1'b1;
            mem_addr_d  = d_addr;
            mem_wr_d    = d_wr;
            mem_wdata_d = d_wdata;
            lock_d      = d_lock;
            tmo_d       = '0;
            if (!i_req) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + 1'b1;
            end
        end else if (grant_i) begin
            state_d     = S_I_ACC;
            mem_req_d   = 1'b1;
            mem_addr_d  = i_addr;
            mem_wr_d    = 1'b0;
            mem_wdata_d = '0;
            lock_d      = 1'b0;
            streak_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= '0;
            locked_q    <= 1'b0;
            lock_err_q  <= 1'b0;
            lock_q      <= 1'b0;
            streak_q    <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            i_done_q    <= i_done_d;
            i_rdata_q   <= i_rdata_d;
            d_done_q    <= d_done_d;
            d_rdata_q   <= d_rdata_d;
            locked_q    <= locked_d;
            lock_err_q  <= lock_err_d;
            lock_q      <= lock_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_done    = i_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign locked    = locked_q;
    assign lock_err  = lock_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus sequences for contention,
// locking, lock timeout and reset during an access.
module tb_mem_port_arbiter;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp;
        int          waits;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic        d_lock;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        locked;
    logic        lock_err;

    int   tests;
    int   fails;
    logic got_done;
    sb_t  sb_q[$];
    vec_t vecs[5];

    mem_port_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .D_STREAK_MAX(4),
        .LOCK_TIMEOUT(64)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_done   (i_done),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_wr     (d_wr),
        .d_lock   (d_lock),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .locked   (locked),
        .lock_err (lock_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [31:0] rd);
        sb_t e;
        e.is_d  = is_d;
        e.rdata = rd;
        sb_q.push_back(e);
    endtask

    // Advance to the next falling edge and retire any completion.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        got_done = i_done | d_done;
        if (i_done && d_done) chkb("both_done", 1'b1, 1'b0);
        if (got_done) begin
            if (sb_q.size() == 0) begin
                chkb("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chkb("done_owner_is_d", d_done, e.is_d);
                chk("done_rdata", d_done ? d_rdata : i_rdata, e.rdata);
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        push(v.is_d, v.exp);
        if (v.is_d) begin
            d_req = 1'b1; d_wr = v.wr; d_lock = 1'b0;
            d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        mem_ready = 1'b0;
        mem_rdata = ~v.rdata;
        tick();
        chkb("latency_mem_req", mem_req, 1'b1);
        chk("mem_addr", mem_addr, v.addr);
        chkb("mem_wr", mem_wr, v.is_d & v.wr);
        chk("mem_wdata", mem_wdata, v.is_d ? v.wdata : 32'h0);
        for (int k = 0; k < v.waits; k++) begin
            tick();
            chkb("wait_mem_req", mem_req, 1'b1);
            chk("wait_mem_addr", mem_addr, v.addr);
        end
        mem_ready = 1'b1;
        mem_rdata = v.rdata;
        tick();
        chkb("done_pulse", got_done, 1'b1);
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        tick();
        chkb("done_one_cycle", i_done | d_done, 1'b0);
        chkb("mem_req_dropped", mem_req, 1'b0);
    endtask

    initial begin
        int ndone;
        int cnt;
        tests = 0; fails = 0; got_done = 1'b0;
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 0};
        vecs[1] = '{1'b1, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 5};
        vecs[2] = '{1'b1, 1'b1, 32'h200, 32'h55, 32'h9999, 32'h0, 0};
        vecs[3] = '{1'b0, 1'b0, 32'h104, 32'h0, 32'h13579BDF, 32'h13579BDF, 2};
        vecs[4] = '{1'b1, 1'b1, 32'h3FC, 32'hA5A5A5A5, 32'h77, 32'h0, 1};

        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
        d_lock = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) tick();
        chk("reset_outputs",
            {mem_req, mem_wr, i_done, d_done, locked, lock_err},
            32'h0);
        chk("reset_mem_addr", mem_addr | mem_wdata, 32'h0);
        chk("reset_rdata", i_rdata | d_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[n]) run_vec(vecs[n]);

        // Contention: D writes and I fetches both held, memory always ready.
        mem_ready = 1'b1; mem_rdata = 32'h0F0F0F0F;
        d_req = 1'b1; d_wr = 1'b1; d_lock = 1'b0;
        d_addr = 32'h200; d_wdata = 32'h55;
        i_req = 1'b1; i_addr = 32'h180;
        for (int k = 0; k < 4; k++) push(1'b1, 32'h0);
        push(1'b0, 32'h0F0F0F0F);
        push(1'b1, 32'h0);
        ndone = 0;
        for (int k = 0; k < 60 && ndone < 6; k++) begin
            tick();
            if (got_done) ndone++;
            if (ndone == 6) begin
                d_req = 1'b0; i_req = 1'b0;
            end
        end
        chk("contention_grants", 32'(ndone), 32'd6);
        d_req = 1'b0; i_req = 1'b0;
        tick();

        // Atomic lock: locked read, then unlocking write, I pending throughout.
        mem_rdata = 32'h12345678;
        d_req = 1'b1; d_wr = 1'b0; d_lock = 1'b1; d_addr = 32'h400;
        d_wdata = 32'h0; i_req = 1'b1; i_addr = 32'h500;
        push(1'b1, 32'h12345678);
        push(1'b1, 32'h0);
        push(1'b0, 32'h12345678);
        tick();
        chk("lock_rd_addr", mem_addr, 32'h400);
        chkb("lock_rd_locked", locked, 1'b0);
        tick();
        chkb("lock_rd_done", d_done, 1'b1);
        d_wr = 1'b1; d_lock = 1'b0; d_wdata = 32'h1;
        tick();
        chkb("lock_held", locked, 1'b1);
        chkb("lock_no_mem_req", mem_req, 1'b0);
        tick();
        chkb("lock_wr_mem_wr", mem_wr, 1'b1);
        chk("lock_wr_wdata", mem_wdata, 32'h1);
        chkb("lock_wr_locked", locked, 1'b1);
        tick();
        chkb("lock_wr_done", d_done, 1'b1);
        chkb("lock_resp_locked", locked, 1'b1);
        d_req = 1'b0;
        tick();
        chkb("lock_released", locked, 1'b0);
        tick();
        chkb("post_lock_i_grant", mem_req, 1'b1);
        chk("post_lock_i_addr", mem_addr, 32'h500);
        tick();
        chkb("post_lock_i_done", i_done, 1'b1);
        i_req = 1'b0;
        tick();

        // Lock timeout with I pending.
        mem_rdata = 32'h0BADF00D;
        d_req = 1'b1; d_wr = 1'b0; d_lock = 1'b1; d_addr = 32'h440;
        i_req = 1'b1; i_addr = 32'h600;
        push(1'b1, 32'h0BADF00D);
        push(1'b0, 32'h0BADF00D);
        tick();
        tick();
        chkb("tmo_rd_done", d_done, 1'b1);
        d_req = 1'b0; d_lock = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (lock_err) break;
            if (locked) cnt++;
        end
        chk("tmo_cycles", 32'(cnt), 32'd64);
        chkb("tmo_lock_err", lock_err, 1'b1);
        chkb("tmo_unlocked", locked, 1'b0);
        tick();
        chkb("tmo_i_grant", mem_req, 1'b1);
        chk("tmo_i_addr", mem_addr, 32'h600);
        tick();
        chkb("tmo_i_done", i_done, 1'b1);
        i_req = 1'b0;
        repeat (3) tick();
        chkb("lock_err_sticky", lock_err, 1'b1);

        // Reset while D_ACC waits on memory.
        mem_ready = 1'b0;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h380;
        tick();
        chkb("rst_pre_mem_req", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chkb("rst_mem_req", mem_req, 1'b0);
        chkb("rst_d_done", d_done, 1'b0);
        chkb("rst_lock_err", lock_err, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        d_req = 1'b0;
        mem_ready = 1'b1;
        tick();
        chkb("rst_no_done", got_done, 1'b0);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        tick();
        run_vec(vecs[1]);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
